sel_pipe_mux: RTL

Parametrised N-way datapath selector with a registered, flow-controlled output. One of NUM_IN WIDTH-bit operands is chosen per transfer, either by binary index or by priority control lines, and delivered through a one-cycle pipeline stage with a two-entry skid buffer. It is used between the register file / ALU / immediate sources and the ALU operand and writeback ports, so the select point can be a pipeline boundary without losing throughput under backpressure.

---
 rtl/sel_pipe_mux_if.sv | 28 ++
 rtl/sel_pipe_mux.sv | 88 ++++++++
 2 files changed

// File: rtl/sel_pipe_mux_if.sv
// Handshake and operand bundle for sel_pipe_mux: upstream transfer side plus
// the registered, flow-controlled downstream side.
interface sel_pipe_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = $clog2(NUM_IN)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN-2:0]       pri;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_err;

    modport slave (
        input  in_valid, sel, pri, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, out_err
    );

    modport master (
        output in_valid, sel, pri, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, out_err
    );
endinterface

// File: rtl/sel_pipe_mux.sv
// N-way operand selector (binary or priority select) feeding a one-stage
// output register backed by a skid entry, so backpressure never costs a bubble.
module sel_pipe_mux #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 3,
    parameter  int MODE   = 0,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input logic            clk,
    input logic            rst_n,
    sel_pipe_mux_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] src;
        logic             err;
    } item_t;

    item_t          r_main;
    item_t          r_skid;
    logic           r_main_valid;
    logic           r_skid_valid;
    item_t          w_new;
    logic [SEL_W:0] w_sel_ext;
    logic           w_acc;
    logic           w_pop;

    // One extra bit on sel keeps the range compare meaningful when NUM_IN is a power of two.
    always_comb begin
        w_new     = '0;
        w_sel_ext = {1'b0, bus.sel};
        if (MODE == 0) begin
            if (w_sel_ext < (SEL_W+1)'(NUM_IN)) begin
                w_new.src = bus.sel;
            end else begin
                w_new.err = 1'b1;
            end
        end else begin
            for (int k = 0; k < NUM_IN-1; k++) begin
                if (bus.pri[k]) begin
                    w_new.src = SEL_W'(k+1);
                end
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_new.src == SEL_W'(i)) begin
                w_new.data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_acc = bus.in_valid && !r_skid_valid;
    assign w_pop = r_main_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_pop) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= w_acc;
                if (w_acc) begin
                    r_skid <= w_new;
                end
            end else if (w_acc) begin
                r_main       <= w_new;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    assign bus.in_ready  = !r_skid_valid;
    assign bus.out_valid = r_main_valid;
    assign bus.out_data  = r_main.data;
    assign bus.out_src   = r_main.src;
    assign bus.out_err   = r_main.err;

endmodule
